mxint_accum_arbiter: RTL and testbench

- Round-robin arbiter that shares one MxInt accumulator among NUM_REQ requester streams.
- Grants a requester for one full accumulation group of IN_DEPTH beats, with no preemption.
- Forwards that requester's blocks to the accumulator, then holds off all input until the accumulated result is accepted.
- Routes the accumulator's output handshake and an owner tag to the consumer. Mantissa and exponent result data bypass this block.

---
 rtl/mxint_accum_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mxint_accum_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxint_accum_arbiter.sv
// Round-robin arbiter that shares one MxInt accumulator among NUM_REQ requester streams.
// A requester owns the accumulator for a whole group of IN_DEPTH beats; all input is then
// held off until the accumulated result has been accepted by the consumer.
// Optional statistics outputs are enabled by defining MXINT_ACCUM_ARB_STATS_EN.
module mxint_accum_arbiter #(
  parameter int unsigned NUM_REQ               = 4,
  parameter int unsigned DATA_IN_0_PRECISION_0 = 8,
  parameter int unsigned DATA_IN_0_PRECISION_1 = 4,
  parameter int unsigned BLOCK_SIZE            = 4,
  parameter int unsigned IN_DEPTH              = 2,
  parameter int unsigned ID_WIDTH              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][DATA_IN_0_PRECISION_0-1:0] mdata_in,
  input  logic [NUM_REQ-1:0][DATA_IN_0_PRECISION_1-1:0]                 edata_in,
  input  logic [NUM_REQ-1:0]                                            in_valid,
  output logic [NUM_REQ-1:0]                                            in_ready,
  output logic [BLOCK_SIZE-1:0][DATA_IN_0_PRECISION_0-1:0]              acc_mdata,
  output logic [DATA_IN_0_PRECISION_1-1:0]                              acc_edata,
  output logic                                                          acc_in_valid,
  input  logic                                                          acc_in_ready,
  input  logic                                                          acc_out_valid,
  output logic                                                          acc_out_ready,
  output logic                                                          result_valid,
  input  logic                                                          result_ready,
  output logic [ID_WIDTH-1:0]                                           result_id,
  output logic                                                          busy
`ifdef MXINT_ACCUM_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]                                      grp_count,
  output logic [31:0]                                                   stall_cycles
`endif
);

  localparam int unsigned CntW = $clog2(IN_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0]  grant_oh;
  logic                sel_valid;
  logic                arb_found;
  logic [ID_WIDTH-1:0] arb_id;

  // (base + off) mod NUM_REQ, computed wide so non-power-of-two NUM_REQ wraps correctly
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return ID_WIDTH'(sum % NUM_REQ);
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_WIDTH-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      oh[j] = (id == ID_WIDTH'(j));
    end
    return oh;
  endfunction

  // Grant decode and payload mux; data is always driven from grant_id so it never goes X
  always_comb begin
    grant_oh  = to_onehot(grant_id_q);
    sel_valid = |(in_valid & grant_oh);
    acc_mdata = mdata_in[0];
    acc_edata = edata_in[0];
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant_oh[j]) begin
        acc_mdata = mdata_in[j];
        acc_edata = edata_in[j];
      end
    end
  end

  // Round-robin search: first valid requester starting at rr_ptr
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && |(in_valid & to_onehot(wrap_add(rr_ptr_q, i)))) begin
        arb_found = 1'b1;
        arb_id    = wrap_add(rr_ptr_q, i);
      end
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    in_ready      = '0;
    acc_in_valid  = 1'b0;
    acc_out_ready = 1'b0;
    result_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          grant_id_d = arb_id;
          beat_cnt_d = '0;
          state_d    = StFeed;
        end
      end
      StFeed: begin
        acc_in_valid = sel_valid;
        in_ready     = grant_oh & {NUM_REQ{acc_in_ready}};
        if (sel_valid && acc_in_ready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_d == CntW'(IN_DEPTH)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Inputs stay blocked here so groups never overlap inside the accumulator
        result_valid  = acc_out_valid;
        acc_out_ready = result_ready;
        if (acc_out_valid && result_ready) begin
          rr_ptr_d = wrap_add(grant_id_q, 1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign result_id = grant_id_q;
  assign busy      = (state_q != StIdle);

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef MXINT_ACCUM_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grp_count_q;
  logic [31:0]              stall_q;
  logic                     stall_event;
  logic                     grp_done;

  assign grp_done    = (state_q == StDrain) && acc_out_valid && result_ready;
  assign stall_event = ((state_q == StFeed) && !acc_in_valid) ||
                       ((state_q == StDrain) && result_valid && !result_ready);

  // Saturating per-requester group counters and stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_count_q <= '0;
      stall_q     <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (grp_done && grant_oh[j] && (grp_count_q[j] != 16'hFFFF)) begin
          grp_count_q[j] <= grp_count_q[j] + 16'd1;
        end
      end
      if (stall_event && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign grp_count    = grp_count_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mxint_accum_arbiter.sv
// Scoreboard bench for mxint_accum_arbiter: directed requester traffic, a small accumulator
// model, and a monitor that checks each result handshake against queued expectations.
module tb_mxint_accum_arbiter;

  localparam int NR    = 4;
  localparam int P0    = 8;
  localparam int P1    = 4;
  localparam int BS    = 4;
  localparam int DEPTH = 2;
  localparam int IDW   = 2;

  // Hand-computed per-requester results: mantissa[0] = r*16+1 summed over 2 beats, exp = r+3
  localparam int SUM0 [NR] = '{2, 34, 66, 98};
  localparam int EXPV [NR] = '{3, 4, 5, 6};

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0][BS-1:0][P0-1:0] mdata_in;
  logic [NR-1:0][P1-1:0]         edata_in;
  logic [NR-1:0]                 in_valid;
  logic [NR-1:0]                 in_ready;
  logic [BS-1:0][P0-1:0]         acc_mdata;
  logic [P1-1:0]                 acc_edata;
  logic                          acc_in_valid;
  logic                          acc_in_ready;
  logic                          acc_out_valid;
  logic                          acc_out_ready;
  logic                          result_valid;
  logic                          result_ready;
  logic [IDW-1:0]                result_id;
  logic                          busy;
`ifdef MXINT_ACCUM_ARB_STATS_EN
  logic [NR-1:0][15:0]           grp_count;
  logic [31:0]                   stall_cycles;
`endif

  always #5 clk = ~clk;

  mxint_accum_arbiter #(
    .NUM_REQ              (NR),
    .DATA_IN_0_PRECISION_0(P0),
    .DATA_IN_0_PRECISION_1(P1),
    .BLOCK_SIZE           (BS),
    .IN_DEPTH             (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mdata_in     (mdata_in),
    .edata_in     (edata_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .acc_mdata    (acc_mdata),
    .acc_edata    (acc_edata),
    .acc_in_valid (acc_in_valid),
    .acc_in_ready (acc_in_ready),
    .acc_out_valid(acc_out_valid),
    .acc_out_ready(acc_out_ready),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_id    (result_id),
    .busy         (busy)
`ifdef MXINT_ACCUM_ARB_STATS_EN
    ,
    .grp_count    (grp_count),
    .stall_cycles (stall_cycles)
`endif
  );

  // Constant per-requester payload
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < BS; k++) mdata_in[r][k] = P0'(r * 16 + k + 1);
      edata_in[r] = P1'(r + 3);
    end
  end

  // Requester model: beats issued by stimulus, beats taken on handshake
  int issued [NR] = '{default: 0};
  int taken  [NR] = '{default: 0};
  logic [NR-1:0] hold = '0;

  always_comb begin
    for (int r = 0; r < NR; r++) in_valid[r] = (issued[r] != taken[r]) && !hold[r];
  end

  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) if (in_valid[r] && in_ready[r]) taken[r] <= taken[r] + 1;
  end

  // Accumulator model: sums beats, presents result once a group is complete
  logic acc_ready_en = 1'b1;
  logic spurious     = 1'b0;
  logic acc_full     = 1'b0;
  int   acc_cnt      = 0;
  int   acc_sum0     = 0;
  logic [P1-1:0] acc_exp = '0;

  assign acc_in_ready  = acc_ready_en && !acc_full;
  assign acc_out_valid = acc_full || spurious;

  always @(posedge clk) begin
    if (rst) begin
      acc_full <= 1'b0;
      acc_cnt  <= 0;
      acc_sum0 <= 0;
    end else if (acc_out_valid && acc_out_ready && acc_full) begin
      acc_full <= 1'b0;
      acc_cnt  <= 0;
      acc_sum0 <= 0;
    end else if (acc_in_valid && acc_in_ready) begin
      acc_sum0 <= acc_sum0 + int'($signed(acc_mdata[0]));
      acc_exp  <= acc_edata;
      acc_cnt  <= acc_cnt + 1;
      if (acc_cnt + 1 == DEPTH) acc_full <= 1'b1;
    end
  end

  // Scoreboard
  typedef struct {int id; int sum0; int ex;} exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_grp(input int r);
    exp_t e;
    e.id = r; e.sum0 = SUM0[r]; e.ex = EXPV[r];
    sb.push_back(e);
  endtask

  // Monitor: result handshakes against the queue, plus per-cycle invariants
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (result_valid && result_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_result: got id %0d, expected no result", result_id);
        end else begin
          e = sb.pop_front();
          chk("result_id", int'(result_id), e.id);
          chk("result_sum0", acc_sum0, e.sum0);
          chk("result_exp", int'(acc_exp), e.ex);
        end
      end
      if (!busy) chk("idle_quiet", int'({result_valid, acc_in_valid, |in_ready, acc_out_ready}), 0);
      if (in_ready != '0) begin
        chk("in_ready_owner", int'(in_ready), 1 << result_id);
        chk("feed_no_result", int'(result_valid), 0);
      end
      if (acc_in_valid) chk("no_overlap", int'(acc_full), 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain_wait(input string name);
    int t = 0;
    while ((sb.size() != 0 || busy || in_valid != '0) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, int'(t < 300), 1);
  endtask

  task automatic wait_taken(input int r, input int target);
    int t = 0;
    while (taken[r] < target && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("wait_taken", int'(t < 100), 1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete, expected finish within 20000 cycles");
    $fatal(1);
  end

  initial begin
    int base;
    int t;
    rst          = 1'b1;
    result_ready = 1'b1;
    cyc(2);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_acc_in_valid", int'(acc_in_valid), 0);
    chk("rst_acc_out_ready", int'(acc_out_ready), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_result_id", int'(result_id), 0);

    // Single requester, cycle-exact: IDLE, beat, beat, drain
    @(posedge clk); #1;
    issued[0] += 2;
    expect_grp(0);
    @(negedge clk);
    chk("t1_arb_busy", int'(busy), 0);
    chk("t1_arb_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("t1_feed_busy", int'(busy), 1);
    chk("t1_feed_ready", int'(in_ready), 1);
    chk("t1_feed_valid", int'(acc_in_valid), 1);
    @(negedge clk);
    chk("t1_beat2_ready", int'(in_ready), 1);
    @(negedge clk);
    chk("t1_drain_rv", int'(result_valid), 1);
    chk("t1_drain_id", int'(result_id), 0);
    chk("t1_drain_ready", int'(in_ready), 0);
    chk("t1_drain_aor", int'(acc_out_ready), 1);
    @(negedge clk);
    chk("t1_done_busy", int'(busy), 0);
    @(posedge clk); #1;

    // rr_ptr advanced to 1: req1 wins over req0
    issued[0] += 2;
    issued[1] += 2;
    expect_grp(1);
    expect_grp(0);
    drain_wait("t1_rr_drain");

    // Round robin from reset with all four requesting
    reset_pulse();
    issued[0] += 4;
    issued[1] += 2;
    issued[2] += 2;
    issued[3] += 2;
    expect_grp(0); expect_grp(1); expect_grp(2); expect_grp(3); expect_grp(0);
    drain_wait("t2_drain");

    // Mid-group stall: req2 drops valid for 3 cycles after beat 1 (rr_ptr is 1)
    base = taken[2];
    issued[2] += 2;
    expect_grp(2);
    wait_taken(2, base + 1);
    hold[2] = 1'b1;
    issued[0] += 2;
    expect_grp(0);
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold_ready", int'(in_ready), 4);
      chk("t3_hold_id", int'(result_id), 2);
      chk("t3_hold_busy", int'(busy), 1);
    end
    @(posedge clk); #1;
    hold[2] = 1'b0;
    drain_wait("t3_drain");

    // Backpressure in DRAIN for 5 cycles
    result_ready = 1'b0;
    issued[3] += 2;
    expect_grp(3);
    t = 0;
    while (!result_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("t4_reach_drain", int'(t < 50), 1);
    issued[1] += 2;
    expect_grp(1);
    repeat (5) begin
      @(negedge clk);
      chk("t4_bp_rv", int'(result_valid), 1);
      chk("t4_bp_aor", int'(acc_out_ready), 0);
      chk("t4_bp_in_ready", int'(in_ready), 0);
      chk("t4_bp_busy", int'(busy), 1);
    end
    @(posedge clk); #1;
    result_ready = 1'b1;
    drain_wait("t4_drain");

    // Reset mid-FEED after 1 of 2 beats (rr_ptr is 2, so req3 is granted)
    base = taken[3];
    issued[3] += 2;
    expect_grp(3);
    wait_taken(3, base + 1);
    hold[3] = 1'b1;
    rst     = 1'b1;
    sb.delete();
    issued[1] += 2;
    @(posedge clk); #1;
    rst       = 1'b0;
    hold[3]   = 1'b0;
    issued[3] += 1;
    expect_grp(1);
    expect_grp(3);
    @(negedge clk);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_in_ready", int'(in_ready), 0);
    chk("t5_rst_aiv", int'(acc_in_valid), 0);
    chk("t5_rst_rv", int'(result_valid), 0);
    chk("t5_rst_aor", int'(acc_out_ready), 0);
    chk("t5_rst_id", int'(result_id), 0);
    @(negedge clk);
    chk("t5_regrant_ready", int'(in_ready), 2);
    @(posedge clk); #1;
    drain_wait("t5_drain");

    // Spurious acc_out_valid outside DRAIN
    spurious = 1'b1;
    @(negedge clk);
    chk("t6_idle_rv", int'(result_valid), 0);
    @(posedge clk); #1;
    issued[2] += 2;
    expect_grp(2);
    @(negedge clk);
    chk("t6_arb_rv", int'(result_valid), 0);
    @(negedge clk);
    chk("t6_feed_rv", int'(result_valid), 0);
    chk("t6_feed_ready", int'(in_ready), 4);
    @(posedge clk); #1;
    drain_wait("t6_drain");
    spurious = 1'b0;

`ifdef MXINT_ACCUM_ARB_STATS_EN
    // Statistics: 3 groups req1, 1 group req3, 2 injected FEED stall cycles
    reset_pulse();
    base = taken[1];
    issued[1] += 6;
    issued[3] += 2;
    expect_grp(1); expect_grp(3); expect_grp(1); expect_grp(1);
    wait_taken(1, base + 1);
    hold[1] = 1'b1;
    cyc(2);
    hold[1] = 1'b0;
    drain_wait("t7_drain");
    chk("t7_grp1", int'(grp_count[1]), 3);
    chk("t7_grp3", int'(grp_count[3]), 1);
    chk("t7_grp0", int'(grp_count[0]), 0);
    chk("t7_stall", int'(stall_cycles), 2);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
